// File: rtl/itof_pipe_pkg.sv
// Shared FPU constants and stage payload types for the int-to-float converter.
package itof_pipe_pkg;

    localparam int unsigned F32_BIAS     = 127;
    localparam int unsigned X_W          = 32;
    localparam int unsigned ITOF_EXP_OFS = F32_BIAS + X_W - 1;
    localparam int unsigned EXP_W        = 8;
    localparam int unsigned MANT_W       = 23;
    localparam int unsigned LZ_W         = 6;
    localparam int unsigned FRAC_W       = X_W - 1;

    // Sign and magnitude after the absolute-value stage.
    typedef struct packed {
        logic           sign;
        logic [X_W-1:0] mag;
    } s1_t;

    // Normalized operand; the implicit leading one is dropped from frac.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } s2_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } f32_t;

endpackage

// File: rtl/itof_pipe_lzc32.sv
// Combinational 32-bit leading-zero counter, result 0..32.
module lzc32
    import itof_pipe_pkg::*;
(
    input  logic [X_W-1:0]  x,
    output logic [LZ_W-1:0] lz
);

    // Highest set bit wins because later iterations override earlier ones.
    always_comb begin
        lz = LZ_W'(X_W);
        for (int i = 0; i < int'(X_W); i++) begin
            if (x[i]) begin
                lz = LZ_W'(int'(X_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 to binary32 converter, round-to-nearest-even, tag passthrough.
module itof_pipe
    import itof_pipe_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X_W-1:0]   in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [X_W-1:0]   out_y,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned MANT_LO = FRAC_W - MANT_W;

    logic             v1, v2, v3;
    logic             en1, en2, en3;
    logic [TAG_W-1:0] t1, t2, t3;
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    f32_t             s3_q, s3_d;
    logic [LZ_W-1:0]  lz;

    logic [MANT_W-1:0] mant;
    logic              lsb, guard, sticky, inc, carry;
    logic [MANT_W:0]   mant_sum;

    // Enable chain: an empty stage always loads, a full one loads only if its successor moves.
    always_comb begin
        en3 = ~v3 | out_ready;
        en2 = ~v2 | en3;
        en1 = ~v1 | en2;
    end

    assign in_ready  = en1;
    assign out_valid = v3;
    assign out_y     = s3_q;
    assign out_tag   = t3;

    always_comb begin
        s1_d.sign = in_x[X_W-1];
        s1_d.mag  = in_x[X_W-1] ? (~in_x + X_W'(1)) : in_x;
    end

    lzc32 u_lzc (
        .x  (s1_q.mag),
        .lz (lz)
    );

    always_comb begin
        s2_d.sign = s1_q.sign;
        s2_d.zero = (s1_q.mag == '0);
        s2_d.exp  = EXP_W'(ITOF_EXP_OFS) - EXP_W'(lz);
        s2_d.frac = FRAC_W'(s1_q.mag << lz);
    end

    // Round to nearest even; a mantissa carry bumps the exponent and leaves mant at zero.
    always_comb begin
        mant     = s2_q.frac[FRAC_W-1:MANT_LO];
        lsb      = s2_q.frac[MANT_LO];
        guard    = s2_q.frac[MANT_LO-1];
        sticky   = |s2_q.frac[MANT_LO-2:0];
        inc      = guard & (sticky | lsb);
        mant_sum = {1'b0, mant} + (MANT_W+1)'(inc);
        carry    = mant_sum[MANT_W];
        s3_d     = '0;
        if (!s2_q.zero) begin
            s3_d.sign = s2_q.sign;
            s3_d.exp  = carry ? (s2_q.exp + EXP_W'(1)) : s2_q.exp;
            s3_d.mant = mant_sum[MANT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1   <= 1'b0;
            s1_q <= '0;
            t1   <= '0;
        end else if (en1) begin
            v1   <= in_valid;
            s1_q <= s1_d;
            t1   <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2   <= 1'b0;
            s2_q <= '0;
            t2   <= '0;
        end else if (en2) begin
            v2   <= v1;
            s2_q <= s2_d;
            t2   <= t1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v3   <= 1'b0;
            s3_q <= '0;
            t3   <= '0;
        end else if (en3) begin
            v3   <= v2;
            s3_q <= s3_d;
            t3   <= t2;
        end
    end

endmodule
